score_keeper: RTL
=================

# score_keeper

Downstream of the game state machine and the block controller. Accumulates the player's score in 4-digit BCD from the per-monster `monster_destroyed` vector and keeps a session high score. Drives the board's multiplexed 4-digit seven-segment display with either value. Owns all scoring arithmetic, so the state machine only issues `clear` and `game_over`.

## Interface
- `L1_PTS`, default 8'h10: BCD points per monster kill while `level` is 0.
- `L2_PTS`, default 8'h20: BCD points per monster kill while `level` is 1.
- `REFRESH_BITS`, default 18: width of the display refresh counter; one digit is shown for 2^REFRESH_BITS cycles.
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `clear`, input, 1: synchronous one-cycle pulse at game start (START state).
- `monster_destroyed`, input, 5: sticky per-monster destroyed bits from the block controller.
- `level`, input, 1: current level, 0 = L1, 1 = L2.
- `game_over`, input, 1: high while the game is in SUCCESS or FAILED.
- `show_high`, input, 1: display the high score instead of the score.
- `score_bcd`, output, 16: current score, 4 BCD digits, digit 3 = MSD.
- `high_bcd`, output, 16: high score, 4 BCD digits.
- `busy`, output, 1: awards pending.
- `an`, output, 4: digit anodes, active-low, one-hot.
- `ssd`, output, 7: segments {g,f,e,d,c,b,a}, active-low.

## Operation
- **Edge detect:** register `prev <= monster_destroyed` every cycle.
  - `new = monster_destroyed & ~prev`.
  - Set `pending <= pending | new`.
  - Falling bits, such as a level re-arm, are ignored.
- **Award serialiser:** each cycle with `pending != 0`:
  - Select the lowest set bit and clear it.
  - Add the points for the current `level` (L1_PTS or L2_PTS) to `score_bcd` with per-digit decimal carry.
  - Exactly one award per cycle.
  - `busy = (pending != 0)`.
- **Saturation:** if the BCD sum exceeds 9999, `score_bcd <= 16'h9999`. The score never wraps.
- **Clear:**
  - `score_bcd <= 0`, `pending <= 0`, `hi_req <= 0`.
  - `prev <= monster_destroyed`, so bits already high award nothing.
  - `clear` overrides any same-cycle new edge or award.
  - `high_bcd` is untouched.
- **High score:**
  - A rising edge of `game_over` sets `hi_req`.
  - When `hi_req` is set and `pending == 0`: if `score_bcd > high_bcd` (plain 16-bit unsigned compare, valid for BCD), then `high_bcd <= score_bcd`. `hi_req` clears in the same cycle either way.
  - Pending awards are therefore always counted before the compare.
- **Display:**
  - A free-running refresh counter advances a 2-bit digit index on each wrap.
  - `an[i]` is low for the selected digit `i`.
  - The source is `high_bcd` if `show_high`, else `score_bcd`.
  - Leading-zero blanking: digits 3..1 are blanked (`ssd = 7'b1111111`) while they and all higher digits are 0. Digit 0 always shows.
  - Non-BCD nibbles display blank.

## Timing
- Reset values:
  - `score_bcd = 0`, `high_bcd = 0`, `busy = 0`.
  - `pending = 0`, `prev = 0`, `hi_req = 0`.
  - Digit index 0, refresh counter 0, `an = 4'b1110`, `ssd = 7'b1000000` (shows "0").
- Award latency: a bit rising before edge k sets `pending` at edge k. The score updates at edge k+1. With m simultaneous rising bits, the last update lands at edge k+m, and `busy` is high for edges k..k+m-1.
- `level` is sampled at the award edge, not the kill edge.
- High-score update lands one edge after `pending` drains, or edge k+1 after the `game_over` edge if `pending` is already empty.
- The display index changes once per 2^REFRESH_BITS cycles. `an` and `ssd` are registered and change on the same edge.
- `rst` mid-award discards `pending` immediately (asynchronous).
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `SCORE_KEEPER_HISCORE_EN` defined: high-score register, `hi_req` logic and `show_high` selection are compiled in.
- Not defined:
  - `high_bcd` is tied to 0.
  - `show_high` is ignored; the display always shows `score_bcd`.
  - `game_over` has no effect.

## Test plan
- **Reset:** assert `rst` mid-run → `score_bcd` 0, `an` 4'b1110, `ssd` 7'b1000000 within the reset cycle; with REFRESH_BITS = 2 the digits cycle 1110 → 1101 → 1011 → 0111 every 4 cycles, with digits 1..3 blank.
- **Simultaneous kills:** with `level` 0, raise bits 0, 2 and 4 in one cycle → `busy` high for 3 cycles and the score steps 0010 → 0020 → 0030. Then `level` 1, raise bits 1 and 3 → the score reaches 0070.
- **Clear:** `clear` on the same cycle as a new rising bit → the score stays 0 and no award follows. Bits held high after `clear` never award.
- **Saturation:** preload the score to 9990 with `level` 1 and one kill → 9999. A further kill stays at 9999.
- **High score:**
  - Score 0050: raise `game_over` while 2 awards are pending → `high_bcd` 0070 after the drain.
  - Next game scoring 0030: `game_over` → `high_bcd` stays 0070.
  - `show_high` = 1 → the display reads "70".
  - Rebuild without the macro → `high_bcd` stays 0.
- **Blanking:** score 0105 → digit 3 blank, digits 2..0 show 1, 0, 5. Score 0000 → only digit 0 shows "0".

Source files
------------

// File: rtl/score_keeper_if.sv
// score_keeper_if
// Groups the game-side controls and the score/display outputs of score_keeper.
// The game logic (or a testbench) drives through the master modport and
// score_keeper sits on the slave modport.
interface score_keeper_if;
   logic        clear;
   logic [4:0]  monster_destroyed;
   logic        level;
   logic        game_over;
   logic        show_high;
   logic [15:0] score_bcd;
   logic [15:0] high_bcd;
   logic        busy;
   logic [3:0]  an;
   logic [6:0]  ssd;

   modport master (
      output clear, monster_destroyed, level, game_over, show_high,
      input  score_bcd, high_bcd, busy, an, ssd
   );

   modport slave (
      input  clear, monster_destroyed, level, game_over, show_high,
      output score_bcd, high_bcd, busy, an, ssd
   );
endinterface

// File: rtl/score_keeper.sv
// score_keeper
// Accumulates the player's score in 4-digit BCD from per-monster destroyed
// bits, optionally keeps a session high score, and drives a multiplexed
// 4-digit active-low seven-segment display.
//
// Build option: define SCORE_KEEPER_HISCORE_EN to compile in the high-score
// register, the game_over request logic and the show_high display selection.
// Without it high_bcd reads 0, show_high and game_over are ignored.
//
// Awards are serialised one per cycle (lowest pending monster first) so the
// BCD adder only ever adds a single points value. The score saturates at 9999.
module score_keeper #(
   parameter logic [7:0]  L1_PTS       = 8'h10,
   parameter logic [7:0]  L2_PTS       = 8'h20,
   parameter int unsigned REFRESH_BITS = 18
) (
   input  logic          clk,
   input  logic          rst,
   score_keeper_if.slave bus_if
);

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Adds a 2-digit BCD value to a 4-digit BCD value; bit 16 is the carry
   // out of the thousands digit, which the caller treats as overflow.
   function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [7:0] b);
      logic [15:0] b_ext;
      logic [15:0] sum;
      logic        carry;
      logic [4:0]  dsum;
      b_ext = {8'h00, b};
      sum   = 16'h0000;
      carry = 1'b0;
      for (int i = 0; i < 4; i++) begin
         dsum = {1'b0, a[i*4 +: 4]} + {1'b0, b_ext[i*4 +: 4]} + {4'b0000, carry};
         if (dsum > 5'd9) begin
            // dsum is 10..19, so subtracting 10 modulo 16 on the low nibble is exact
            sum[i*4 +: 4] = dsum[3:0] - 4'd10;
            carry         = 1'b1;
         end else begin
            sum[i*4 +: 4] = dsum[3:0];
            carry         = 1'b0;
         end
      end
      return {carry, sum};
   endfunction

   // Active-low {g,f,e,d,c,b,a} pattern for one digit; non-BCD nibbles are blank.
   function automatic logic [6:0] seg_encode(input logic [3:0] digit, input logic blank);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = SEG_BLANK;
      endcase
      return blank ? SEG_BLANK : seg;
   endfunction

   // Leading-zero mask: a digit above 0 is blank while it and every higher
   // digit are zero. The units digit always shows.
   function automatic logic [3:0] blank_mask(input logic [15:0] v);
      logic [3:0] mask;
      mask[3] = (v[15:12] == 4'h0);
      mask[2] = mask[3] && (v[11:8] == 4'h0);
      mask[1] = mask[2] && (v[7:4] == 4'h0);
      mask[0] = 1'b0;
      return mask;
   endfunction

   // ---------------------------------------------------------------------
   // Award path
   // ---------------------------------------------------------------------
   logic [4:0]  prev_q;
   logic [4:0]  prev_d;
   logic [4:0]  pending_q;
   logic [4:0]  pending_d;
   logic [15:0] score_q;
   logic [15:0] score_d;
   logic [4:0]  new_s;
   logic [4:0]  low_s;
   logic [7:0]  pts_s;
   logic [16:0] sum_s;

   // Rising-edge capture into pending, one award per cycle, clear override.
   always_comb begin
      new_s     = bus_if.monster_destroyed & ~prev_q;
      low_s     = pending_q & (~pending_q + 5'd1);
      pts_s     = bus_if.level ? L2_PTS : L1_PTS;
      sum_s     = bcd_add(score_q, pts_s);
      prev_d    = bus_if.monster_destroyed;
      pending_d = pending_q;
      score_d   = score_q;
      if (bus_if.clear) begin
         // prev still follows the input so bits already high never award
         pending_d = 5'b00000;
         score_d   = 16'h0000;
      end else if (pending_q != 5'b00000) begin
         pending_d = (pending_q & ~low_s) | new_s;
         if (sum_s[16]) begin
            score_d = 16'h9999;
         end else begin
            score_d = sum_s[15:0];
         end
      end else begin
         pending_d = new_s;
         score_d   = score_q;
      end
   end

   // Edge-detect history, pending awards and the running score.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q    <= 5'b00000;
         pending_q <= 5'b00000;
         score_q   <= 16'h0000;
      end else begin
         prev_q    <= prev_d;
         pending_q <= pending_d;
         score_q   <= score_d;
      end
   end

   // ---------------------------------------------------------------------
   // High score
   // ---------------------------------------------------------------------
   logic [15:0] high_s;
   logic [15:0] disp_src_s;

`ifdef SCORE_KEEPER_HISCORE_EN
   logic [15:0] high_q;
   logic [15:0] high_d;
   logic        hi_req_q;
   logic        hi_req_d;
   logic        go_prev_q;
   logic        go_prev_d;
   logic        go_rise_s;
   logic        hi_service_s;

   // Latch a game_over edge; compare only once every pending award is counted.
   always_comb begin
      go_prev_d    = bus_if.game_over;
      go_rise_s    = bus_if.game_over & ~go_prev_q;
      hi_service_s = hi_req_q && (pending_q == 5'b00000);
      if (bus_if.clear) begin
         hi_req_d = 1'b0;
      end else if (go_rise_s) begin
         hi_req_d = 1'b1;
      end else if (hi_service_s) begin
         hi_req_d = 1'b0;
      end else begin
         hi_req_d = hi_req_q;
      end
      // BCD digits order the same way as plain binary, so an unsigned compare works
      if (hi_service_s && (score_q > high_q)) begin
         high_d = score_q;
      end else begin
         high_d = high_q;
      end
   end

   // High-score value, pending request and game_over history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         high_q    <= 16'h0000;
         hi_req_q  <= 1'b0;
         go_prev_q <= 1'b0;
      end else begin
         high_q    <= high_d;
         hi_req_q  <= hi_req_d;
         go_prev_q <= go_prev_d;
      end
   end

   assign high_s     = high_q;
   assign disp_src_s = bus_if.show_high ? high_q : score_q;
`else
   logic unused_hi_s;

   assign unused_hi_s = bus_if.game_over ^ bus_if.show_high;
   assign high_s      = 16'h0000;
   assign disp_src_s  = score_q;
`endif

   // ---------------------------------------------------------------------
   // Display multiplexer
   // ---------------------------------------------------------------------
   logic [REFRESH_BITS-1:0] refresh_q;
   logic [REFRESH_BITS-1:0] refresh_d;
   logic [1:0]              idx_q;
   logic [1:0]              idx_d;
   logic [3:0]              an_q;
   logic [3:0]              an_d;
   logic [6:0]              ssd_q;
   logic [6:0]              ssd_d;
   logic [3:0]              blank_s;
   logic [3:0]              digit_s;

   // Step the digit index on refresh wrap; an and ssd come from the next index
   // so both change on the same edge.
   always_comb begin
      refresh_d = refresh_q + REFRESH_BITS'(1);
      if (refresh_q == {REFRESH_BITS{1'b1}}) begin
         idx_d = idx_q + 2'd1;
      end else begin
         idx_d = idx_q;
      end
      blank_s = blank_mask(disp_src_s);
      digit_s = disp_src_s[{idx_d, 2'b00} +: 4];
      an_d    = ~(4'b0001 << idx_d);
      ssd_d   = seg_encode(digit_s, blank_s[idx_d]);
   end

   // Refresh counter, digit index and registered display drive.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         refresh_q <= '0;
         idx_q     <= 2'd0;
         an_q      <= 4'b1110;
         ssd_q     <= 7'b1000000;
      end else begin
         refresh_q <= refresh_d;
         idx_q     <= idx_d;
         an_q      <= an_d;
         ssd_q     <= ssd_d;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs (all taken from registers)
   // ---------------------------------------------------------------------
   assign bus_if.score_bcd = score_q;
   assign bus_if.high_bcd  = high_s;
   assign bus_if.busy      = (pending_q != 5'b00000);
   assign bus_if.an        = an_q;
   assign bus_if.ssd       = ssd_q;

endmodule
